// File: rtl/e203_exu_bjp_resolve_q.sv
// In-order branch resolution queue: holds predicted branch/jump/fence.i
// records, checks the head against the actual BJP outcome, and raises a
// registered flush with the corrected PC on a mispredict.
module e203_exu_bjp_resolve_q #(
  parameter int XLEN   = 32,
  parameter int DEPTH  = 4,
  parameter int STAT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enq_valid,
  output logic                     enq_ready,
  input  logic [XLEN-1:0]          enq_pc,
  input  logic                     enq_rv32,
  input  logic                     enq_prdt_taken,
  input  logic [XLEN-1:0]          enq_prdt_tgt,
  input  logic                     res_valid,
  output logic                     res_ready,
  input  logic                     res_bxx,
  input  logic                     res_jump,
  input  logic                     res_fencei,
  input  logic                     res_cmp_res,
  input  logic [XLEN-1:0]          res_tgt,
  output logic                     flush_valid,
  input  logic                     flush_ready,
  output logic [XLEN-1:0]          flush_pc,
  output logic [$clog2(DEPTH):0]   count,
  output logic [STAT_W-1:0]        mispred_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic            rv32;
    logic            prdt_taken;
    logic [XLEN-1:0] prdt_tgt;
  } bjp_rec_t;

  bjp_rec_t        mem [DEPTH];
  bjp_rec_t        head;
  logic [AW-1:0]   wptr, rptr;
  logic            full, empty;
  logic            enq_fire, res_fire;
  logic            act_taken, mispred;
  logic [XLEN-1:0] seq_pc, act_pc;

  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);
  assign enq_ready = !full && !flush_valid;
  assign res_ready = !empty && !flush_valid;
  assign enq_fire  = enq_valid && enq_ready;
  assign res_fire  = res_valid && res_ready;

  // Head outcome: actual direction, next PC, and whether the prediction held.
  always_comb begin
    head      = mem[rptr];
    seq_pc    = head.pc + (head.rv32 ? XLEN'(4) : XLEN'(2));
    act_taken = res_jump || (res_bxx && res_cmp_res);
    act_pc    = res_fencei ? seq_pc : (act_taken ? res_tgt : seq_pc);
    mispred   = res_fencei
             || (act_taken != head.prdt_taken)
             || (act_taken && (res_tgt != head.prdt_tgt));
  end

  // Record storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (enq_fire) mem[wptr] <= '{pc: enq_pc, rv32: enq_rv32,
                                 prdt_taken: enq_prdt_taken,
                                 prdt_tgt: enq_prdt_tgt};
  end

  // Pointers, occupancy, flush handshake and mispredict statistics.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr        <= '0;
      rptr        <= '0;
      count       <= '0;
      flush_valid <= 1'b0;
      flush_pc    <= '0;
      mispred_cnt <= '0;
    end else begin
      // Nothing fires while a flush is pending, so clearing here never
      // races with a new mispredict.
      if (flush_valid && flush_ready) flush_valid <= 1'b0;
      if (res_fire && mispred) begin
        // Drop the head and everything younger, including a same-cycle enqueue.
        flush_valid <= 1'b1;
        flush_pc    <= act_pc;
        rptr        <= rptr + 1'b1;
        wptr        <= rptr + 1'b1;
        count       <= '0;
        if (mispred_cnt != '1) mispred_cnt <= mispred_cnt + 1'b1;
      end else begin
        if (enq_fire) wptr <= wptr + 1'b1;
        if (res_fire) rptr <= rptr + 1'b1;
        count <= count + CW'(enq_fire) - CW'(res_fire);
      end
    end
  end

endmodule

// File: tb/tb_e203_exu_bjp_resolve_q.sv
// Bench for the branch resolution queue: directed scenarios followed by a
// randomized run, all checked against a queue-based reference model.
module tb_e203_exu_bjp_resolve_q;
  localparam int XLEN   = 32;
  localparam int DEPTH  = 4;
  localparam int STAT_W = 2;
  localparam int CNT_MAX = (1 << STAT_W) - 1;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic                   enq_valid, enq_ready, enq_rv32, enq_prdt_taken;
  logic [XLEN-1:0]        enq_pc, enq_prdt_tgt;
  logic                   res_valid, res_ready, res_bxx, res_jump, res_fencei, res_cmp_res;
  logic [XLEN-1:0]        res_tgt;
  logic                   flush_valid, flush_ready;
  logic [XLEN-1:0]        flush_pc;
  logic [$clog2(DEPTH):0] count;
  logic [STAT_W-1:0]      mispred_cnt;

  always #5 clk = ~clk;

  e203_exu_bjp_resolve_q #(.XLEN(XLEN), .DEPTH(DEPTH), .STAT_W(STAT_W)) dut (
    .clk(clk), .rst(rst),
    .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_pc(enq_pc),
    .enq_rv32(enq_rv32), .enq_prdt_taken(enq_prdt_taken), .enq_prdt_tgt(enq_prdt_tgt),
    .res_valid(res_valid), .res_ready(res_ready), .res_bxx(res_bxx),
    .res_jump(res_jump), .res_fencei(res_fencei), .res_cmp_res(res_cmp_res),
    .res_tgt(res_tgt),
    .flush_valid(flush_valid), .flush_ready(flush_ready), .flush_pc(flush_pc),
    .count(count), .mispred_cnt(mispred_cnt)
  );

  typedef struct {
    logic [31:0] pc;
    bit          rv32;
    bit          pt;
    logic [31:0] tgt;
  } rec_t;

  rec_t        mq[$];
  bit          m_fv;
  logic [31:0] m_fpc;
  int          m_mc;
  int          n_chk = 0;
  int          n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic idle_in();
    enq_valid = 0; enq_pc = '0; enq_rv32 = 0; enq_prdt_taken = 0; enq_prdt_tgt = '0;
    res_valid = 0; res_bxx = 0; res_jump = 0; res_fencei = 0; res_cmp_res = 0; res_tgt = '0;
  endtask

  // One clock: check readiness, predict the edge with the model, check state after.
  task automatic cycle();
    bit eok, rok, efire, rfire, mis, at, fhs;
    logic [31:0] seq, apc;
    rec_t h, nr;
    eok = (mq.size() < DEPTH) && !m_fv;
    rok = (mq.size() > 0) && !m_fv;
    chk("enq_ready", enq_ready, eok);
    chk("res_ready", res_ready, rok);
    efire = enq_valid && eok;
    rfire = res_valid && rok;
    fhs   = m_fv && flush_ready;
    nr    = '{enq_pc, enq_rv32, enq_prdt_taken, enq_prdt_tgt};
    mis = 0; apc = '0;
    if (rfire) begin
      h   = mq[0];
      seq = h.pc + (h.rv32 ? 32'd4 : 32'd2);
      at  = res_jump || (res_bxx && res_cmp_res);
      apc = res_fencei ? seq : (at ? res_tgt : seq);
      mis = res_fencei || (at != h.pt) || (at && res_tgt != h.tgt);
    end
    @(posedge clk); #1;
    if (fhs) m_fv = 0;
    if (rfire) void'(mq.pop_front());
    if (mis) begin
      mq.delete();
      m_fv = 1; m_fpc = apc;
      if (m_mc < CNT_MAX) m_mc++;
    end else if (efire) mq.push_back(nr);
    chk("count", count, mq.size());
    chk("flush_valid", flush_valid, m_fv);
    chk("mispred_cnt", mispred_cnt, m_mc);
    if (m_fv) chk("flush_pc", flush_pc, m_fpc);
  endtask

  task automatic do_reset();
    idle_in();
    flush_ready = 0;
    #3 rst = 1;
    #1;
    chk("rst_count", count, 0);
    chk("rst_flush_valid", flush_valid, 0);
    chk("rst_flush_pc", flush_pc, 0);
    chk("rst_mispred_cnt", mispred_cnt, 0);
    chk("rst_enq_ready", enq_ready, 1);
    chk("rst_res_ready", res_ready, 0);
    @(negedge clk);
    rst = 0;
    mq.delete(); m_fv = 0; m_fpc = '0; m_mc = 0;
  endtask

  task automatic enq(input logic [31:0] pc, input bit rv, input bit pt, input logic [31:0] tgt);
    enq_valid = 1; enq_pc = pc; enq_rv32 = rv; enq_prdt_taken = pt; enq_prdt_tgt = tgt;
    cycle();
    enq_valid = 0;
  endtask

  task automatic res(input bit bxx, input bit jmp, input bit fi, input bit cmp, input logic [31:0] tgt);
    res_valid = 1; res_bxx = bxx; res_jump = jmp; res_fencei = fi; res_cmp_res = cmp; res_tgt = tgt;
    cycle();
    res_valid = 0; res_bxx = 0; res_jump = 0; res_fencei = 0; res_cmp_res = 0;
  endtask

  // Drive an outcome that agrees with the model's head record.
  task automatic drive_res_good();
    res_bxx = 0; res_jump = 0; res_fencei = 0; res_cmp_res = 0;
    res_valid = 1;
    if (mq[0].pt) begin
      if ($urandom_range(1, 0) == 1) res_jump = 1;
      else begin res_bxx = 1; res_cmp_res = 1; end
      res_tgt = mq[0].tgt;
    end else begin
      res_bxx = 1; res_cmp_res = 0; res_tgt = $urandom;
    end
  endtask

  initial begin
    idle_in();
    flush_ready = 0;
    mq.delete(); m_fv = 0; m_fpc = '0; m_mc = 0;
    #2;
    chk("init_count", count, 0);
    chk("init_flush_valid", flush_valid, 0);
    repeat (2) @(negedge clk);
    rst = 0;

    // Correct prediction: pop only.
    enq(32'h100, 1, 1, 32'h200);
    res(1, 0, 0, 1, 32'h200);
    chk("ok_count", count, 0);
    chk("ok_flush", flush_valid, 0);
    chk("ok_mcnt", mispred_cnt, 0);

    // Direction mispredict drops the two younger records.
    enq(32'h80, 0, 1, 32'h90);
    enq(32'h84, 1, 0, 32'h0);
    enq(32'h88, 1, 0, 32'h0);
    res(1, 0, 0, 0, 32'h90);
    chk("dir_flush_pc", flush_pc, 32'h82);
    chk("dir_count", count, 0);
    chk("dir_mcnt", mispred_cnt, 1);
    enq_valid = 1; enq_pc = 32'h500;
    res_valid = 1; res_bxx = 1;
    repeat (3) cycle();
    idle_in();

    // Reset mid-flush, then with two records queued.
    do_reset();
    enq(32'h10, 1, 0, 0);
    enq(32'h14, 1, 0, 0);
    do_reset();

    // Target mispredict on a jump, then fence.i.
    enq(32'h10, 1, 1, 32'h304);
    res(0, 1, 0, 0, 32'h300);
    chk("tgt_flush_pc", flush_pc, 32'h300);
    flush_ready = 1; cycle(); flush_ready = 0;
    enq(32'h40, 1, 0, 32'h0);
    res(0, 0, 1, 0, 32'h123);
    chk("fencei_flush_pc", flush_pc, 32'h44);
    flush_ready = 1; cycle(); flush_ready = 0;

    // Full: no bypass, then wrap with paired enqueue/resolve.
    do_reset();
    for (int i = 0; i < 4; i++) enq(32'h1000 + i * 4, 1, $urandom_range(1, 0), 32'h2000 + i * 8);
    chk("full_enq_ready", enq_ready, 0);
    enq_valid = 1; enq_pc = 32'h1010; enq_rv32 = 1; enq_prdt_taken = 1; enq_prdt_tgt = 32'h2020;
    drive_res_good();
    cycle();
    chk("full_nobypass_count", count, 3);
    res_valid = 0;
    cycle();
    chk("full_refill_count", count, 4);
    enq_valid = 0;
    drive_res_good(); cycle(); res_valid = 0;
    for (int i = 0; i < 10; i++) begin
      enq_valid = 1; enq_pc = 32'h3000 + i * 2; enq_rv32 = i[0];
      enq_prdt_taken = i[1]; enq_prdt_tgt = 32'h4000 + i * 16;
      drive_res_good();
      cycle();
    end
    idle_in();
    chk("wrap_count", count, 3);
    chk("wrap_mcnt", mispred_cnt, 0);

    // Counter saturation.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      enq(32'h600 + i * 4, 1, 0, 0);
      res(0, 0, 1, 0, 0);
      flush_ready = 1; cycle(); flush_ready = 0;
    end
    chk("sat_mcnt", mispred_cnt, CNT_MAX);

    // Randomized traffic.
    do_reset();
    for (int n = 0; n < 800; n++) begin
      idle_in();
      enq_valid      = ($urandom_range(2, 0) != 0);
      enq_pc         = $urandom & 32'hffff_fffe;
      enq_rv32       = $urandom_range(1, 0);
      enq_prdt_taken = $urandom_range(1, 0);
      enq_prdt_tgt   = $urandom & 32'hffff_fffe;
      if (mq.size() > 0 && $urandom_range(4, 0) != 0) begin
        drive_res_good();
        res_valid = ($urandom_range(3, 0) != 0);
      end else begin
        res_valid = $urandom_range(1, 0);
        case ($urandom_range(3, 0))
          1: res_bxx = 1;
          2: res_jump = 1;
          3: res_fencei = 1;
          default: ;
        endcase
        res_cmp_res = $urandom_range(1, 0);
        res_tgt = (mq.size() > 0 && $urandom_range(1, 0) == 1) ? mq[0].tgt : $urandom;
      end
      flush_ready = ($urandom_range(2, 0) != 0);
      cycle();
    end
    idle_in();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
